// File: rtl/apb_mem_slave.sv
// APB4 completer with a word-addressed register memory.
// Byte strobes, fixed wait states, PSLVERR on out-of-range access.
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  in_rng;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  setup;
  logic                  go_ready;

  assign in_rng  = 32'(paddr) < 32'(MEM_DEPTH);
  assign idx     = paddr[IDX_W-1:0];
  assign rd_word = in_rng ? mem[idx] : '0;
  assign setup   = psel && !penable;

  // pready is registered, so the response is loaded one edge early
  always_comb begin
    go_ready = 1'b0;
    unique case (state)
      IDLE:    go_ready = setup && (WAIT_STATES == 0);
      ACCESS:  go_ready = !pready && psel && (cnt == 4'd1);
      default: go_ready = 1'b0;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
            cnt   <= 4'(WAIT_STATES);
          end
        end
        ACCESS: begin
          if (pready) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            if (psel && pwrite && in_rng) begin
              for (int i = 0; i < STRB_WIDTH; i++) begin
                if (pstrb[i]) begin
                  mem[idx][8*i +: 8] <= pwdata[8*i +: 8];
                end
              end
            end
          end else if (!psel) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
      if (go_ready) begin
        pready  <= 1'b1;
        pslverr <= !in_rng;
        if (!pwrite) begin
          prdata <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Randomised bench for apb_mem_slave against a memory model.
// Instance 0 uses two wait states, instance 1 uses none.
module tb_apb_mem_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic [7:0]  paddr   [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  logic [31:0] mdl [2][64];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_mem_slave #(.WAIT_STATES(2)) u_ws2 (
    .pclk(pclk), .preset(preset), .paddr(paddr[0]),
    .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .preset(preset), .paddr(paddr[1]),
    .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1])
  );

  function automatic int exp_lat(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic logic [31:0] exp_read(input int d, input logic [7:0] a);
    return (a < 64) ? mdl[d][a[5:0]] : 32'h0;
  endfunction

  task automatic model_write(input int d, input logic [7:0] a,
                             input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] m;
    m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    if (a < 64) mdl[d][a[5:0]] = (mdl[d][a[5:0]] & ~m) | (wd & m);
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) mdl[d][i] = 32'h0;
  endtask

  // Called at a negedge; returns at the negedge after the ready cycle.
  task automatic apb_xfer(input int d, input bit wr, input logic [7:0] a,
                          input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output logic err,
                          output int lat);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    @(negedge pclk);
    penable[d] = 1'b1;
    lat = 1;
    while (pready[d] !== 1'b1 && lat < 40) begin
      @(negedge pclk);
      lat++;
    end
    rd = prdata[d];
    err = pslverr[d];
    @(negedge pclk);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int lat;
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (pready[d] !== 1'b0 || pslverr[d] !== 1'b0 || prdata[d] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state d%0d: got rdy=%b err=%b rd=%h need 0 0 0",
                 d, pready[d], pslverr[d], prdata[d]);
      end
    end
    preset = 1'b0;
    model_clear();
    @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      apb_xfer(d, 0, 8'h05, 32'h0, 4'h0, rd, err, lat);
      n_checks++;
      if (rd !== 32'h0 || err !== 1'b0 || lat != exp_lat(d)) begin
        n_fail++;
        $display("FAIL reset_read d%0d: got rd=%h err=%b lat=%0d need 0 0 %0d",
                 d, rd, err, lat, exp_lat(d));
      end
    end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(0, 1, 8'h10, 32'hDEADBEEF, 4'b1111, rd, err, lat);
    model_write(0, 8'h10, 32'hDEADBEEF, 4'b1111);
    n_checks++;
    if (err !== 1'b0 || lat != 3) begin
      n_fail++;
      $display("FAIL strb_write: got err=%b lat=%0d need 0 3", err, lat);
    end
    apb_xfer(0, 1, 8'h10, 32'h11223344, 4'b0101, rd, err, lat);
    model_write(0, 8'h10, 32'h11223344, 4'b0101);
    apb_xfer(0, 1, 8'h10, 32'hFFFFFFFF, 4'b0000, rd, err, lat);
    n_checks++;
    if (err !== 1'b0 || lat != 3) begin
      n_fail++;
      $display("FAIL strb_zero: got err=%b lat=%0d need 0 3", err, lat);
    end
    apb_xfer(0, 0, 8'h10, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'hDE22BE44 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL strb_read: got %h err=%b need DE22BE44 0", rd, err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(0, 1, 8'h40, 32'hCAFEF00D, 4'hF, rd, err, lat);
    n_checks++;
    if (err !== 1'b1 || lat != 3) begin
      n_fail++;
      $display("FAIL err_write40: got err=%b lat=%0d need 1 3", err, lat);
    end
    apb_xfer(0, 0, 8'hFF, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_readFF: got err=%b rd=%h need 1 0", err, rd);
    end
    for (int a = 0; a < 64; a++) begin
      apb_xfer(0, 0, 8'(a), 32'h0, 4'h0, rd, err, lat);
      n_checks++;
      if (rd !== exp_read(0, 8'(a)) || err !== 1'b0) begin
        n_fail++;
        $display("FAIL err_scan a=%h: got %h err=%b need %h 0",
                 a, rd, err, exp_read(0, 8'(a)));
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int lat;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h20; pwdata[0] = 32'hAAAAAAAA; pstrb[0] = 4'hF;
    @(negedge pclk);
    penable[0] = 1'b1;
    @(negedge pclk);
    psel[0] = 1'b0; penable[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_rdy c%0d: got rdy=%b err=%b need 0 0",
                 i, pready[0], pslverr[0]);
      end
      @(negedge pclk);
    end
    // ACCESS without a SETUP must be ignored
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = 8'h21;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      n_checks++;
      if (pready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL nosetup_rdy c%0d: got %b need 0", i, pready[0]);
      end
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge pclk);
    apb_xfer(0, 0, 8'h20, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== exp_read(0, 8'h20)) begin
      n_fail++;
      $display("FAIL abort_read: got %h need %h", rd, exp_read(0, 8'h20));
    end
    apb_xfer(0, 0, 8'h21, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== exp_read(0, 8'h21)) begin
      n_fail++;
      $display("FAIL nosetup_read: got %h need %h", rd, exp_read(0, 8'h21));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int lat;
    apb_xfer(0, 1, 8'h30, 32'h55AA55AA, 4'hF, rd, err, lat);
    model_write(0, 8'h30, 32'h55AA55AA, 4'hF);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 8'h30; pwdata[0] = 32'h77777777; pstrb[0] = 4'hF;
    @(negedge pclk);
    penable[0] = 1'b1;
    preset = 1'b1;
    @(negedge pclk);
    n_checks++;
    if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_rdy: got rdy=%b err=%b need 0 0", pready[0], pslverr[0]);
    end
    preset = 1'b0;
    psel[0] = 1'b0; penable[0] = 1'b0;
    model_clear();
    @(negedge pclk);
    apb_xfer(0, 0, 8'h30, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_read: got %h err=%b need 0 0", rd, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat;
    int t0;
    for (int d = 0; d < 2; d++) begin
      t0 = int'($time);
      apb_xfer(d, 1, 8'h01, 32'h12345678, 4'hF, rd, err, lat);
      model_write(d, 8'h01, 32'h12345678, 4'hF);
      apb_xfer(d, 0, 8'h01, 32'h0, 4'h0, rd, err, lat);
      n_checks++;
      if (rd !== 32'h12345678 || lat != exp_lat(d)) begin
        n_fail++;
        $display("FAIL b2b_read d%0d: got %h lat=%0d need 12345678 %0d",
                 d, rd, lat, exp_lat(d));
      end
      n_checks++;
      if (int'($time) - t0 != 2 * 10 * (exp_lat(d) + 1)) begin
        n_fail++;
        $display("FAIL b2b_rate d%0d: got %0d ns need %0d ns",
                 d, int'($time) - t0, 20 * (exp_lat(d) + 1));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd; logic err; int lat;
    logic [7:0] a; logic [3:0] st; bit wr;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        a  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255))
                                         : 8'($urandom_range(0, 15));
        wr = 1'($urandom_range(0, 1));
        wd = $urandom;
        st = 4'($urandom);
        apb_xfer(d, wr, a, wd, st, rd, err, lat);
        n_checks++;
        if (err !== (a >= 64) || lat != exp_lat(d)) begin
          n_fail++;
          $display("FAIL rnd_rsp d%0d a=%h: got err=%b lat=%0d need %b %0d",
                   d, a, err, lat, a >= 64, exp_lat(d));
        end
        if (wr) begin
          model_write(d, a, wd, st);
        end else begin
          n_checks++;
          if (rd !== exp_read(d, a)) begin
            n_fail++;
            $display("FAIL rnd_read d%0d a=%h: got %h need %h",
                     d, a, rd, exp_read(d, a));
          end
        end
        if ($urandom_range(0, 1) == 1) @(negedge pclk);
      end
    end
  endtask

  initial begin
    preset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      paddr[d] = '0; psel[d] = 1'b0; penable[d] = 1'b0;
      pwrite[d] = 1'b0; pwdata[d] = '0; pstrb[d] = '0;
    end
    model_clear();
    @(negedge pclk);
    test_reset();
    test_strobes();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
